// File: rtl/alu_share_arbiter_if.sv
// Bus bundle for the shared-ALU arbiter: requester job channel, shared ALU
// operand/result bus and the tagged response channel.
interface alu_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 6,
  parameter int OPW   = 3,
  parameter int IDW   = 3
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*OPW-1:0]   req_op;
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [OPW-1:0]         alu_op;
  logic                   alu_en;
  logic [WIDTH-1:0]       alu_result;
  logic [3:0]             alu_flags;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTH-1:0]       rsp_result;
  logic [3:0]             rsp_flags;
  logic                   busy;

  // Arbiter side: accepts jobs, drives the ALU, returns responses.
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_flags, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_id,
           rsp_result, rsp_flags, busy
  );

  // Environment side: requesters, ALU datapath and response consumer.
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, alu_en, rsp_valid, rsp_id,
           rsp_result, rsp_flags, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among N_REQ requesters.
// IDLE grants one job, EXEC holds the operands for ALU_LAT cycles and
// captures the result, RESP presents it tagged with the requester index.
module alu_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 6,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1,
  parameter int IDW     = 3
) (
  input logic          clk,
  input logic          reset,
  alu_share_arbiter_if.slave bus
);

  localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LCW = $clog2(ALU_LAT + 1);
  localparam logic [LCW-1:0] LAT_LAST = LCW'(ALU_LAT - 1);
  localparam logic [PW-1:0]  LAST_REQ = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [PW-1:0]     rr_ptr_r;
  logic [PW-1:0]     rr_next_s;
  logic [PW-1:0]     grant_idx_s;
  logic [PW-1:0]     scan_idx_s;
  logic              grant_found_s;
  logic              accept_s;
  logic              capture_s;
  logic [LCW-1:0]    lat_cnt_r;
  int                scan_s;

  logic [WIDTH-1:0]  alu_a_r;
  logic [WIDTH-1:0]  alu_b_r;
  logic [OPW-1:0]    alu_op_r;
  logic              alu_en_r;
  logic              rsp_valid_r;
  logic [IDW-1:0]    rsp_id_r;
  logic [WIDTH-1:0]  rsp_result_r;
  logic [3:0]        rsp_flags_r;
  logic              busy_r;

  // Round-robin scan: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {PW{1'b0}};
    scan_s        = 0;
    scan_idx_s    = {PW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      scan_s     = (int'(rr_ptr_r) + i) % N_REQ;
      scan_idx_s = PW'(scan_s);
      if (!grant_found_s && bus.req_valid[scan_idx_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_idx_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer advances to the requester just after the winner.
  always_comb begin
    rr_next_s = {PW{1'b0}};
    if (grant_idx_s == LAST_REQ) begin
      rr_next_s = {PW{1'b0}};
    end else begin
      rr_next_s = grant_idx_s + PW'(1'b1);
    end
  end

  // Next-state logic and the accept/capture strobes derived from it.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_found_s && reset) begin
          accept_s     = 1'b1;
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        if (lat_cnt_r == LAT_LAST) begin
          capture_s    = 1'b1;
          state_next_s = RESP;
        end else begin
          state_next_s = EXEC;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // One-hot grant, combinational so a requester sees acceptance in-cycle.
  always_comb begin
    bus.req_ready = {N_REQ{1'b0}};
    if (accept_s) begin
      bus.req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      bus.req_ready = {N_REQ{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch at accept, latency count in EXEC, result capture at exit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_r     <= {PW{1'b0}};
      lat_cnt_r    <= {LCW{1'b0}};
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      alu_op_r     <= {OPW{1'b0}};
      rsp_id_r     <= {IDW{1'b0}};
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_flags_r  <= 4'b0000;
    end else begin
      if (accept_s) begin
        alu_a_r   <= bus.req_a[grant_idx_s*WIDTH +: WIDTH];
        alu_b_r   <= bus.req_b[grant_idx_s*WIDTH +: WIDTH];
        alu_op_r  <= bus.req_op[grant_idx_s*OPW +: OPW];
        rsp_id_r  <= IDW'(grant_idx_s);
        rr_ptr_r  <= rr_next_s;
        lat_cnt_r <= {LCW{1'b0}};
      end else if (state_r == EXEC) begin
        lat_cnt_r <= lat_cnt_r + LCW'(1'b1);
      end
      if (capture_s) begin
        rsp_result_r <= bus.alu_result;
        rsp_flags_r  <= bus.alu_flags;
      end
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_en_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      alu_en_r    <= (state_next_s == EXEC);
      rsp_valid_r <= (state_next_s == RESP);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  assign bus.alu_a      = alu_a_r;
  assign bus.alu_b      = alu_b_r;
  assign bus.alu_op     = alu_op_r;
  assign bus.alu_en     = alu_en_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_flags  = rsp_flags_r;
  assign bus.busy       = busy_r;

endmodule
